// File: rtl/disp_sched.sv
// Display scheduler for the 3-digit multiplexed 7-segment display.
// Latency: 1 cycle input-to-output; every output comes straight from a flop.
// Backpressure: msg_req/msg_ack handshake; requests are accepted only in LIVE and
// wait while an alarm or another message holds the display.
//
// Ports:
//   clk, rst           clock (rising edge) and synchronous active-high reset
//   cnt_d0..cnt_d2     live ticket count digits (units, tens, hundreds)
//   msg_req/msg_ack    message request (held until ack) / one-cycle accept pulse
//   msg_d0..msg_d2     message digits, latched on accept
//   alm_req            level-sensitive alarm request, highest priority
//   out_d0..out_d2     digits to the display multiplexer
//   src, busy          current source (0 LIVE, 1 MSG, 2 ALARM), busy = src != LIVE
//
// Optional build macro: LZB_EN enables leading-zero blanking of the live count.
module disp_sched #(
  parameter int          HOLD_CYC  = 50000000,
  parameter int          BLINK_CYC = 12500000,
  parameter logic [3:0]  ALM_CODE  = 4'hE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] cnt_d0,
  input  logic [3:0] cnt_d1,
  input  logic [3:0] cnt_d2,
  input  logic       msg_req,
  input  logic [3:0] msg_d0,
  input  logic [3:0] msg_d1,
  input  logic [3:0] msg_d2,
  output logic       msg_ack,
  input  logic       alm_req,
  output logic [3:0] out_d0,
  output logic [3:0] out_d1,
  output logic [3:0] out_d2,
  output logic [1:0] src,
  output logic       busy
);

  localparam logic [3:0] BLANK = 4'hF;

  // Counter widths; a single-cycle blink period still needs a 1-bit counter.
  localparam int TW = (HOLD_CYC  > 1) ? $clog2(HOLD_CYC)  : 1;
  localparam int BW = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;

  localparam logic [TW-1:0] HOLD_LAST  = TW'(HOLD_CYC - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYC - 1);

  typedef enum logic [1:0] {
    ST_LIVE  = 2'd0,
    ST_MSG   = 2'd1,
    ST_ALARM = 2'd2
  } state_t;

  state_t          state_q, state_nxt;
  logic [TW-1:0]   timer_q, timer_nxt;
  logic [BW-1:0]   blink_q, blink_nxt;
  logic            phase_q, phase_nxt;   // 1 = on phase (alarm code shown)
  logic [2:0][3:0] msg_q,   msg_nxt;
  logic [2:0][3:0] out_q,   out_nxt;
  logic            ack_q,   ack_nxt;
  logic            busy_q;

  // Live digits as they should appear on the display.
  logic [2:0][3:0] live_dig;

  always_comb begin
    live_dig[0] = cnt_d0;
    live_dig[1] = cnt_d1;
    live_dig[2] = cnt_d2;
`ifdef LZB_EN
    // Units digit is never blanked so a zero count still reads "  0".
    if (cnt_d2 == 4'd0) begin
      live_dig[2] = BLANK;
      if (cnt_d1 == 4'd0) begin
        live_dig[1] = BLANK;
      end
    end
`endif
  end

  // Next-state and next-output logic. The output flops are loaded from the
  // state being entered, so src and the digits always change on the same edge.
  always_comb begin
    state_nxt = state_q;
    timer_nxt = '0;
    blink_nxt = '0;
    phase_nxt = 1'b1;
    msg_nxt   = msg_q;
    out_nxt   = out_q;
    ack_nxt   = 1'b0;

    case (state_q)
      ST_LIVE: begin
        out_nxt = live_dig;
        if (alm_req) begin
          // Alarm wins; a simultaneous message request stays pending unacked.
          state_nxt = ST_ALARM;
          out_nxt   = {ALM_CODE, ALM_CODE, ALM_CODE};
        end else if (msg_req) begin
          state_nxt  = ST_MSG;
          msg_nxt[0] = msg_d0;
          msg_nxt[1] = msg_d1;
          msg_nxt[2] = msg_d2;
          out_nxt[0] = msg_d0;
          out_nxt[1] = msg_d1;
          out_nxt[2] = msg_d2;
          ack_nxt    = 1'b1;
          timer_nxt  = HOLD_LAST;
        end
      end

      ST_MSG: begin
        if (alm_req) begin
          // Abort the message; it is not resumed after the alarm.
          state_nxt = ST_ALARM;
          out_nxt   = {ALM_CODE, ALM_CODE, ALM_CODE};
        end else if (timer_q == '0) begin
          // Return to LIVE; msg_req is not looked at here, which guarantees
          // at least one LIVE cycle before the next message is accepted.
          state_nxt = ST_LIVE;
          out_nxt   = live_dig;
        end else begin
          timer_nxt = timer_q - 1'b1;
          out_nxt   = msg_q;
        end
      end

      ST_ALARM: begin
        if (!alm_req) begin
          state_nxt = ST_LIVE;
          out_nxt   = live_dig;
        end else begin
          if (blink_q == BLINK_LAST) begin
            blink_nxt = '0;
            phase_nxt = ~phase_q;
          end else begin
            blink_nxt = blink_q + 1'b1;
            phase_nxt = phase_q;
          end
          out_nxt = phase_nxt ? {ALM_CODE, ALM_CODE, ALM_CODE}
                              : {BLANK, BLANK, BLANK};
        end
      end

      default: begin
        state_nxt = ST_LIVE;
        out_nxt   = live_dig;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_LIVE;
      timer_q <= '0;
      blink_q <= '0;
      phase_q <= 1'b1;
      msg_q   <= '0;
      out_q   <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      timer_q <= timer_nxt;
      blink_q <= blink_nxt;
      phase_q <= phase_nxt;
      msg_q   <= msg_nxt;
      out_q   <= out_nxt;
      ack_q   <= ack_nxt;
      busy_q  <= (state_nxt != ST_LIVE);
    end
  end

  assign out_d0  = out_q[0];
  assign out_d1  = out_q[1];
  assign out_d2  = out_q[2];
  assign msg_ack = ack_q;
  assign src     = state_q;
  assign busy    = busy_q;

endmodule
